// File: rtl/preset_setter_pkg.sv
// Shared definitions for the preset entry unit.
//   state_e     : editing FSM states.
//   bcd_time_t  : one min:sec:10ms value, each field two BCD digits.
//   SEC_MAX / MS10_MAX : fixed field maxima.
//   bcd_step()  : one BCD increment/decrement with wrap at 0 / max.
package preset_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_MIN = 2'd1,
    EDIT_SEC = 2'd2,
    EDIT_MS  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] ms10;
  } bcd_time_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MS10_MAX = 8'h99;

  // Per-nibble step. Counting up from max_val wraps to 00, counting
  // down from 00 wraps to max_val; otherwise the low digit carries or
  // borrows into the high digit.
  function automatic logic [7:0] bcd_step(input logic [7:0] value,
                                          input logic [7:0] max_val,
                                          input logic       up);
    logic [7:0] result;
    result = value;
    if (up) begin
      if (value == max_val)
        result = 8'h00;
      else if (value[3:0] == 4'h9)
        result = {value[7:4] + 4'h1, 4'h0};
      else
        result = {value[7:4], value[3:0] + 4'h1};
    end else begin
      if (value == 8'h00)
        result = max_val;
      else if (value[3:0] == 4'h0)
        result = {value[7:4] - 4'h1, 4'h9};
      else
        result = {value[7:4], value[3:0] - 4'h1};
    end
    return result;
  endfunction

endpackage

// File: rtl/preset_setter_if.sv
// Button and preset bus of the preset entry unit.
//   slave  : the preset_setter itself (buttons/lock in, presets out).
//   master : the front-end side driving buttons and reading presets.
interface preset_setter_if;
  logic       lock;
  logic       btn_sel;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_commit;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic [7:0] ms_10_o;
  logic [7:0] min_edit;
  logic [7:0] sec_edit;
  logic [7:0] ms_10_edit;
  logic [2:0] field_o;
  logic       editing;
  logic       load;
  logic       err;

  modport slave (
    input  lock, btn_sel, btn_inc, btn_dec, btn_commit,
    output min_o, sec_o, ms_10_o, min_edit, sec_edit, ms_10_edit,
           field_o, editing, load, err
  );

  modport master (
    output lock, btn_sel, btn_inc, btn_dec, btn_commit,
    input  min_o, sec_o, ms_10_o, min_edit, sec_edit, ms_10_edit,
           field_o, editing, load, err
  );
endinterface

// File: rtl/preset_setter_btn_repeat.sv
// Edge detect plus auto-repeat for one step button.
//   clk_core : system clock
//   rst      : synchronous active-low reset
//   btn      : synchronised, debounced button level
//   step_o   : one-cycle step request, high in the cycle the rising edge
//              is sampled and on each auto-repeat
// The first repeat comes REPEAT_DELAY cycles after the edge, then one
// every REPEAT_PERIOD cycles while the button stays high.
module btn_repeat #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk_core,
  input  logic rst,
  input  logic btn,
  output logic step_o
);

  localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXV + 1);

  logic          prev_reg;
  logic [CW-1:0] cnt_reg;
  logic          repeating_reg;
  logic          rise;
  logic          held;
  logic          hit;

  assign rise = btn & ~prev_reg;
  assign held = btn & prev_reg;
  // cnt_reg holds the number of cycles since the last step
  assign hit  = held & (repeating_reg ? (cnt_reg == CW'(REPEAT_PERIOD))
                                      : (cnt_reg == CW'(REPEAT_DELAY)));
  assign step_o = rise | hit;

  always_ff @(posedge clk_core) begin
    if (!rst) begin
      prev_reg      <= 1'b0;
      cnt_reg       <= '0;
      repeating_reg <= 1'b0;
    end else begin
      prev_reg <= btn;
      if (!btn) begin
        cnt_reg       <= '0;
        repeating_reg <= 1'b0;
      end else if (rise) begin
        cnt_reg       <= CW'(1);
        repeating_reg <= 1'b0;
      end else if (hit) begin
        cnt_reg       <= CW'(1);
        repeating_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/preset_setter.sv
// Preset entry unit: select a field, step it in BCD, commit the result
// to the countdown core.
//   clk_core : system clock, all logic on its rising edge
//   rst      : synchronous active-low reset
//   bus      : preset_setter_if.slave
//              in : lock, btn_sel, btn_inc, btn_dec, btn_commit
//              out: min_o/sec_o/ms_10_o (committed), min_edit/sec_edit/
//                   ms_10_edit (working), field_o (one-hot, [2]=min),
//                   editing, load, err
// Build option: PRESET_ZERO_GUARD_EN rejects a commit of 00:00.00 with an
// err pulse; without it a zero commit is accepted and err is tied low.
module preset_setter
  import preset_pkg::*;
#(
  parameter int         REPEAT_DELAY  = 500,
  parameter int         REPEAT_PERIOD = 100,
  parameter logic [7:0] MIN_MAX       = 8'h99
) (
  input  logic clk_core,
  input  logic rst,
  preset_setter_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_EDIT_MIN = EDIT_MIN;
  localparam logic [1:0] ST_EDIT_SEC = EDIT_SEC;
  localparam logic [1:0] ST_EDIT_MS  = EDIT_MS;

  logic [1:0] state_reg;
  bcd_time_t  working_reg;
  bcd_time_t  committed_reg;
  logic       sel_prev_reg;
  logic       commit_prev_reg;
  logic       load_reg;
  logic       err_reg;

  logic       inc_step;
  logic       dec_step;
  logic       sel_rise;
  logic       commit_rise;
  logic       do_step;
  logic       zero_reject;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .clk_core (clk_core),
    .rst      (rst),
    .btn      (bus.btn_inc),
    .step_o   (inc_step)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .clk_core (clk_core),
    .rst      (rst),
    .btn      (bus.btn_dec),
    .step_o   (dec_step)
  );

  assign sel_rise    = bus.btn_sel & ~sel_prev_reg;
  assign commit_rise = bus.btn_commit & ~commit_prev_reg;
  // Simultaneous inc and dec cancel out
  assign do_step     = inc_step ^ dec_step;

`ifdef PRESET_ZERO_GUARD_EN
  assign zero_reject = (working_reg == '0);
`else
  assign zero_reject = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      working_reg     <= '0;
      committed_reg   <= '0;
      sel_prev_reg    <= 1'b0;
      commit_prev_reg <= 1'b0;
      load_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      sel_prev_reg    <= bus.btn_sel;
      commit_prev_reg <= bus.btn_commit;
      load_reg        <= 1'b0;
      err_reg         <= 1'b0;
      if (bus.lock) begin
        state_reg   <= ST_IDLE;
        working_reg <= committed_reg;
      end else if (state_reg != ST_IDLE && commit_rise) begin
        // Commit takes priority over field selection and stepping
        if (zero_reject) begin
          err_reg <= 1'b1;
        end else begin
          committed_reg <= working_reg;
          load_reg      <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      end else begin
        if (sel_rise) begin
          case (state_reg)
            ST_IDLE:     state_reg <= ST_EDIT_MIN;
            ST_EDIT_MIN: state_reg <= ST_EDIT_SEC;
            ST_EDIT_SEC: state_reg <= ST_EDIT_MS;
            default:     state_reg <= ST_EDIT_MIN;
          endcase
        end
        if (do_step) begin
          case (state_reg)
            ST_EDIT_MIN: working_reg.min  <= bcd_step(working_reg.min,  MIN_MAX,  inc_step);
            ST_EDIT_SEC: working_reg.sec  <= bcd_step(working_reg.sec,  SEC_MAX,  inc_step);
            ST_EDIT_MS:  working_reg.ms10 <= bcd_step(working_reg.ms10, MS10_MAX, inc_step);
            default:     ;
          endcase
        end
      end
    end
  end

  assign bus.min_o      = committed_reg.min;
  assign bus.sec_o      = committed_reg.sec;
  assign bus.ms_10_o    = committed_reg.ms10;
  assign bus.min_edit   = working_reg.min;
  assign bus.sec_edit   = working_reg.sec;
  assign bus.ms_10_edit = working_reg.ms10;
  assign bus.load       = load_reg;
`ifdef PRESET_ZERO_GUARD_EN
  assign bus.err        = err_reg;
`else
  assign bus.err        = 1'b0;
`endif
  assign bus.editing    = (state_reg != ST_IDLE);
  assign bus.field_o    = (state_reg == ST_EDIT_MIN) ? 3'b100 :
                          (state_reg == ST_EDIT_SEC) ? 3'b010 :
                          (state_reg == ST_EDIT_MS)  ? 3'b001 : 3'b000;

endmodule

// File: tb/tb_preset_setter.sv
// Directed bench for preset_setter: field selection, BCD stepping and
// wrap, auto-repeat timing, commit, lock and zero commit handling.
module tb_preset_setter;

  logic clk_core = 1'b0;
  logic rst      = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  preset_setter_if bus ();

  preset_setter #(
    .REPEAT_DELAY  (500),
    .REPEAT_PERIOD (100),
    .MIN_MAX       (8'h99)
  ) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_core = ~clk_core;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic press_sel();
    bus.btn_sel = 1'b1; tick(1);
    bus.btn_sel = 1'b0; tick(1);
  endtask

  task automatic press_commit();
    bus.btn_commit = 1'b1; tick(1);
    bus.btn_commit = 1'b0;
  endtask

  // n short taps of inc (up=1) or dec (up=0)
  task automatic tap(input logic up, input int n);
    for (int i = 0; i < n; i++) begin
      if (up) bus.btn_inc = 1'b1; else bus.btn_dec = 1'b1;
      tick(1);
      bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    bus.lock = 1'b0; bus.btn_sel = 1'b0; bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0; bus.btn_commit = 1'b0;
    tick(3);
    check_eq("rst_field",   bus.field_o, 3'b000);
    check_eq("rst_editing", bus.editing, 1'b0);
    check_eq("rst_load",    bus.load, 1'b0);
    check_eq("rst_err",     bus.err, 1'b0);
    check_eq("rst_commit",  {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h000000);
    check_eq("rst_work",    {bus.min_edit, bus.sec_edit, bus.ms_10_edit}, 24'h000000);
    rst = 1'b1;
    tick(1);

    // Field selection ring
    press_sel();
    check_eq("sel1_field", bus.field_o, 3'b100);
    check_eq("sel1_edit",  bus.editing, 1'b1);
    press_sel(); check_eq("sel2_field", bus.field_o, 3'b010);
    press_sel(); check_eq("sel3_field", bus.field_o, 3'b001);
    press_sel(); check_eq("sel4_field", bus.field_o, 3'b100);

    // Seconds: 00 -> 59 -> 58, then 59, 00, 59
    press_sel();
    tap(1'b0, 1); check_eq("sec_dec_wrap", bus.sec_edit, 8'h59);
    tap(1'b0, 1); check_eq("sec_dec",      bus.sec_edit, 8'h58);
    tap(1'b1, 1); check_eq("sec_inc",      bus.sec_edit, 8'h59);
    tap(1'b1, 1); check_eq("sec_inc_wrap", bus.sec_edit, 8'h00);
    tap(1'b0, 1); check_eq("sec_dec_wrap2", bus.sec_edit, 8'h59);

    // 10ms field: wrap both ways, then auto-repeat
    press_sel();
    check_eq("ms_field", bus.field_o, 3'b001);
    tap(1'b0, 1); check_eq("ms_dec_wrap", bus.ms_10_edit, 8'h99);
    tap(1'b1, 1); check_eq("ms_inc_wrap", bus.ms_10_edit, 8'h00);
    bus.btn_inc = 1'b1;
    tick(1);   check_eq("rep_edge",   bus.ms_10_edit, 8'h01);
    tick(499); check_eq("rep_before", bus.ms_10_edit, 8'h01);
    tick(1);   check_eq("rep_first",  bus.ms_10_edit, 8'h02);
    tick(299); check_eq("rep_three",  bus.ms_10_edit, 8'h04);
    bus.btn_inc = 1'b0;
    tick(1);
    // Simultaneous inc and dec edges: no change
    bus.btn_inc = 1'b1; bus.btn_dec = 1'b1;
    tick(1);   check_eq("inc_dec_same", bus.ms_10_edit, 8'h04);
    bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    tick(1);

    // Build 12:34.56 from 00:59.04
    press_sel();
    tap(1'b0, 1);  check_eq("min_dec_wrap", bus.min_edit, 8'h99);
    tap(1'b1, 1);  check_eq("min_inc_wrap", bus.min_edit, 8'h00);
    tap(1'b1, 12); check_eq("min_inc_12",   bus.min_edit, 8'h12);
    press_sel();
    tap(1'b0, 25); check_eq("sec_34", bus.sec_edit, 8'h34);
    press_sel();
    tap(1'b1, 52); check_eq("ms_56",  bus.ms_10_edit, 8'h56);
    check_eq("pre_commit_out", {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h000000);
    press_commit();
    check_eq("commit_load",  bus.load, 1'b1);
    check_eq("commit_value", {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h123456);
    check_eq("commit_field", bus.field_o, 3'b000);
    tick(1);
    check_eq("load_single",  bus.load, 1'b0);

    // Commit 01:00.00, with a borrow check on the way down
    press_sel();
    tap(1'b0, 3);  check_eq("min_borrow", bus.min_edit, 8'h09);
    tap(1'b0, 8);  check_eq("min_01",     bus.min_edit, 8'h01);
    press_sel(); tap(1'b0, 34);
    press_sel(); tap(1'b0, 56);
    press_commit();
    check_eq("commit2_value", {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h010000);
    tick(1);

    // Lock discards the uncommitted edit
    press_sel();
    tap(1'b1, 4);  check_eq("min_05", bus.min_edit, 8'h05);
    bus.lock = 1'b1;
    tick(1);
    check_eq("lock_field",   bus.field_o, 3'b000);
    check_eq("lock_editing", bus.editing, 1'b0);
    check_eq("lock_reload",  bus.min_edit, 8'h01);
    check_eq("lock_load",    bus.load, 1'b0);
    press_sel();
    check_eq("lock_sel_ign", bus.field_o, 3'b000);
    bus.lock = 1'b0;
    tick(1);

    // Commit in IDLE is ignored
    press_commit();
    check_eq("idle_commit_load", bus.load, 1'b0);
    tick(1);

    // Zero commit
    press_sel();
    tap(1'b0, 1);  check_eq("work_zero", {bus.min_edit, bus.sec_edit, bus.ms_10_edit}, 24'h000000);
    press_commit();
`ifdef PRESET_ZERO_GUARD_EN
    check_eq("zero_err",     bus.err, 1'b1);
    check_eq("zero_load",    bus.load, 1'b0);
    check_eq("zero_editing", bus.editing, 1'b1);
    check_eq("zero_keep",    {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h010000);
    tick(1);
    check_eq("zero_err_single", bus.err, 1'b0);
`else
    check_eq("zero_load",    bus.load, 1'b1);
    check_eq("zero_err",     bus.err, 1'b0);
    check_eq("zero_editing", bus.editing, 1'b0);
    check_eq("zero_value",   {bus.min_o, bus.sec_o, bus.ms_10_o}, 24'h000000);
    tick(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preset_setter.md
Name: preset_setter

Overview:
- User-facing preset entry unit that produces the BCD min:sec:10ms target consumed by the countdown core.
- Button presses select a field and step it up or down with BCD wrap. Held buttons auto-repeat.
- A commit publishes the working value as the committed preset and emits a one-cycle load pulse.
- Sits between the button front-end (pulses already synchronised and debounced) and the countdown datapath.

Parameters:
- REPEAT_DELAY, 500: clk_core cycles a step button must be held before auto-repeat starts.
- REPEAT_PERIOD, 100: clk_core cycles between auto-repeat steps once repeating.
- MIN_MAX, 8'h99: BCD maximum of the minute field. Seconds max is fixed 8'h59; 10ms max is fixed 8'h99.

Ports:
- clk_core  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- lock  in  1  high while the countdown runs; editing is disabled.
- btn_sel  in  1  level, synchronous; rising edge advances the selected field.
- btn_inc  in  1  level, synchronous; step selected field +1, auto-repeats while held.
- btn_dec  in  1  level, synchronous; step selected field -1, auto-repeats while held.
- btn_commit  in  1  level, synchronous; rising edge commits.
- min_o  out  8  committed minutes, BCD.
- sec_o  out  8  committed seconds, BCD.
- ms_10_o  out  8  committed 10ms units, BCD.
- min_edit  out  8  working minutes, for display.
- sec_edit  out  8  working seconds, for display.
- ms_10_edit  out  8  working 10ms units, for display.
- field_o  out  3  one-hot selected field: [2]=min, [1]=sec, [0]=ms_10; 000 when idle.
- editing  out  1  high in any EDIT state.
- load  out  1  one-cycle pulse on a successful commit.
- err  out  1  one-cycle pulse on a rejected commit.

Behaviour:
- Reset (rst=0 at clock edge):
  - All committed and working values become 8'h00.
  - State becomes IDLE; field_o=000; editing, load and err are 0.
  - Edge detectors and repeat counters clear.
- FSM states: IDLE, EDIT_MIN, EDIT_SEC, EDIT_MS.
  - btn_sel rising edge: IDLE->EDIT_MIN->EDIT_SEC->EDIT_MS->EDIT_MIN.
  - btn_commit rising edge in any EDIT state: committed <= working, load=1 next cycle, state->IDLE.
  - btn_commit in IDLE is ignored.
  - btn_sel and btn_commit edges in the same cycle: commit wins.
- lock=1:
  - State is forced to IDLE.
  - Working values are reloaded from the committed values, discarding uncommitted edits.
  - All buttons are ignored; load and err stay 0.
- Stepping:
  - Only in EDIT states, applied to the selected field, effective the cycle after the step event.
  - A step event is a rising edge of btn_inc or btn_dec.
  - Holding the button for REPEAT_DELAY cycles after the edge gives the first repeat step, then one step every REPEAT_PERIOD cycles.
  - Releasing the button resets its repeat counter.
  - inc and dec step events in the same cycle: no change.
  - Changing field while a button is held: the repeat counter continues and repeats apply to the new field.
- BCD arithmetic is per nibble, never binary. Each field is always valid BCD.
  - inc: low nibble 9->0 carries into the high nibble; field max wraps to 8'h00.
  - dec: low nibble 0->9 borrows from the high nibble; 8'h00 wraps to the field max.
  - Examples: sec 8'h59 +1 -> 8'h00; ms_10 8'h00 -1 -> 8'h99; min 8'h40 -1 -> 8'h39.
- Outputs are registered. field_o and editing are decoded from the registered state.

Optional Feature:
- Macro PRESET_ZERO_GUARD_EN.
- Defined: committing a working value of 00:00.00 is rejected. State stays in the current EDIT state, committed values are unchanged, load=0, and err pulses for one cycle.
- Undefined: a zero commit is accepted like any other value, and err is tied 0.

Decomposition:
- Shared package preset_pkg holds:
  - the state enum (IDLE, EDIT_MIN, EDIT_SEC, EDIT_MS);
  - BCD constants SEC_MAX=8'h59 and MS10_MAX=8'h99;
  - a BCD step function (value, max, up/down) returning the wrapped BCD result.
- One sequential sub-module, btn_repeat, instantiated twice (inc and dec). It contains:
  - an edge detector;
  - a delay/period counter;
  - a one-cycle step pulse output.

Test Plan:
- Reset then btn_sel edge -> field_o=100, editing=1. 3 more sel edges -> field_o cycles 010, 001, 100.
- EDIT_SEC at 8'h58, two inc edges -> sec_edit 8'h59 then 8'h00. One dec edge -> 8'h59.
- EDIT_MS, btn_inc held REPEAT_DELAY+3*REPEAT_PERIOD cycles from 8'h00 -> ms_10_edit=8'h04 (1 edge + 3 repeats).
- Working 12:34.56, commit edge -> min_o=8'h12, sec_o=8'h34, ms_10_o=8'h56, single load pulse, field_o=000.
- Committed 01:00.00, edit min to 8'h05, assert lock -> state IDLE, min_edit returns to 8'h01, no load.
- Macro defined, working 00:00.00, commit -> err pulse, editing stays 1, committed unchanged. Macro undefined -> load pulse.
